// File: rtl/uart_rx_ctrl.sv
// Purpose: UART RX controller: idle-gated config updates, received-byte FIFO, error/overflow status.
// Latency: config applies >= 2 cycles after cfg_wr; pushed byte is visible on out_data 1 cycle later.
// Backpressure: out_valid/out_ready; a byte arriving at a full FIFO without a pop is dropped and flags overflow.
//
// Ports:
//   clk, rst            - clock and synchronous active-low reset
//   cfg_*               - host config write request and its pending/ack/err status
//   Prescale/PAR_EN/PAR_TYP - live configuration driven to the RX datapath
//   rx_*                - RX FSM status, received byte and error pulses
//   out_data/out_valid/out_ready, fifo_count - consumer side of the byte FIFO
//   overflow, par_err_cnt, stop_err_cnt, clr_stat - status for the register file
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr,
    input  logic [5:0]                   cfg_prescale,
    input  logic                         cfg_par_en,
    input  logic                         cfg_par_typ,
    output logic                         cfg_pending,
    output logic                         cfg_ack,
    output logic                         cfg_err,
    output logic [5:0]                   Prescale,
    output logic                         PAR_EN,
    output logic                         PAR_TYP,
    input  logic                         rx_busy,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         rx_data_valid,
    input  logic                         rx_par_err,
    input  logic                         rx_stop_err,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    output logic [ERR_CNT_W-1:0]         par_err_cnt,
    output logic [ERR_CNT_W-1:0]         stop_err_cnt,
    input  logic                         clr_stat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    // ---------------- configuration FSM ----------------
    typedef enum logic [1:0] {CFG_IDLE, CFG_WAIT, CFG_APPLY} cfg_state_t;

    cfg_state_t state;
    logic [5:0] sh_prescale;
    logic       sh_par_en;
    logic       sh_par_typ;
    logic       prescale_legal;

    assign prescale_legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) ||
                            (cfg_prescale == 6'd32);

    // Live config is loaded on the WAIT->APPLY transition so the new values and
    // cfg_ack are both visible during the APPLY cycle. RX only samples config when
    // leaving IDLE, so rx_busy rising during APPLY cannot see a half-updated set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CFG_IDLE;
            Prescale    <= 6'd8;
            PAR_EN      <= 1'b1;
            PAR_TYP     <= 1'b0;
            sh_prescale <= 6'd8;
            sh_par_en   <= 1'b1;
            sh_par_typ  <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                CFG_IDLE: begin
                    if (cfg_wr) begin
                        if (prescale_legal) begin
                            sh_prescale <= cfg_prescale;
                            sh_par_en   <= cfg_par_en;
                            sh_par_typ  <= cfg_par_typ;
                            cfg_pending <= 1'b1;
                            state       <= CFG_WAIT;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                CFG_WAIT: begin
                    if (!rx_busy) begin
                        Prescale    <= sh_prescale;
                        PAR_EN      <= sh_par_en;
                        PAR_TYP     <= sh_par_typ;
                        cfg_ack     <= 1'b1;
                        cfg_pending <= 1'b0;
                        state       <= CFG_APPLY;
                    end
                end
                CFG_APPLY: state <= CFG_IDLE;
                default:   state <= CFG_IDLE;
            endcase
        end
    end

    // ---------------- byte FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_inc;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  ovf_evt;
    logic [CNT_W-1:0]      count_next;

    assign full       = (fifo_count == CNT_W'(DEPTH));
    assign pop        = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = rx_data_valid && (!full || pop);
    assign ovf_evt    = rx_data_valid && full && !pop;
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            fifo_count <= count_next;
            out_valid  <= (count_next != '0);
            // out_data is a registered copy of the head. The head comes from rx_data
            // when the pushed byte becomes the only entry, else from the next slot.
            if (pop) begin
                if (fifo_count == CNT_W'(1)) begin
                    if (push) out_data <= rx_data;
                end else begin
                    out_data <= mem[rd_ptr_inc];
                end
            end else if (fifo_count == '0 && push) begin
                out_data <= rx_data;
            end
        end
    end

    // ---------------- status ----------------
    // Clear wins over the old value but not over a same-cycle event.
    function automatic logic [ERR_CNT_W-1:0] sat_next(input logic [ERR_CNT_W-1:0] c,
                                                      input logic evt, input logic clr);
        if (clr)                       return ERR_CNT_W'(evt);
        else if (evt && c != ERR_MAX)  return c + 1'b1;
        else                           return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow     <= 1'b0;
            par_err_cnt  <= '0;
            stop_err_cnt <= '0;
        end else begin
            overflow     <= clr_stat ? ovf_evt : (overflow | ovf_evt);
            par_err_cnt  <= sat_next(par_err_cnt, rx_par_err, clr_stat);
            stop_err_cnt <= sat_next(stop_err_cnt, rx_stop_err, clr_stat);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int EW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr;
    logic [5:0]    cfg_prescale;
    logic          cfg_par_en;
    logic          cfg_par_typ;
    logic          cfg_pending;
    logic          cfg_ack;
    logic          cfg_err;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          rx_busy;
    logic [DW-1:0] rx_data;
    logic          rx_data_valid;
    logic          rx_par_err;
    logic          rx_stop_err;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [EW-1:0] par_err_cnt;
    logic [EW-1:0] stop_err_cnt;
    logic          clr_stat;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .cfg_pending(cfg_pending), .cfg_ack(cfg_ack),
        .cfg_err(cfg_err), .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .rx_busy(rx_busy), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_par_err(rx_par_err), .rx_stop_err(rx_stop_err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow),
        .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt), .clr_stat(clr_stat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] pre;
        logic       en;
        logic       typ;
    } cfg_t;

    int           checks = 0;
    int           errors = 0;
    cfg_t         cfg_q[$];
    logic [5:0]   err_q[$];
    logic [DW-1:0] data_q[$];
    cfg_t         exp_live;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: consumes expected items whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid && out_ready) begin
                if (data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fifo_pop_unexpected: got 0x%0h expected none", out_data);
                end else begin
                    check("fifo_data", out_data, data_q.pop_front());
                end
            end
            if (cfg_ack) begin
                if (cfg_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cfg_ack_unexpected: got ack expected none");
                end else begin
                    cfg_t e;
                    e = cfg_q.pop_front();
                    check("cfg_applied", {Prescale, PAR_EN, PAR_TYP}, e);
                    exp_live = e;
                end
            end
            if (cfg_err) begin
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cfg_err_unexpected: got err expected none");
                end else begin
                    void'(err_q.pop_front());
                    check("cfg_err_live_kept", {Prescale, PAR_EN, PAR_TYP}, exp_live);
                end
            end
        end
    end

    task automatic check_reset();
        check("rst_prescale", Prescale, 8);
        check("rst_par_en", PAR_EN, 1);
        check("rst_par_typ", PAR_TYP, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_ack", cfg_ack, 0);
        check("rst_err", cfg_err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_par_cnt", par_err_cnt, 0);
        check("rst_stop_cnt", stop_err_cnt, 0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        rx_data = d;
        rx_data_valid = 1'b1;
        step();
        rx_data_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        step();
        while (out_valid && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check({name, "_drained"}, out_valid, 0);
        check({name, "_sb_empty"}, data_q.size(), 0);
    endtask

    task automatic cfg_write(input logic [5:0] p, input logic en, input logic typ);
        cfg_prescale = p;
        cfg_par_en = en;
        cfg_par_typ = typ;
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; cfg_wr = 0; cfg_prescale = 0; cfg_par_en = 0; cfg_par_typ = 0;
        rx_busy = 0; rx_data = 0; rx_data_valid = 0; rx_par_err = 0; rx_stop_err = 0;
        out_ready = 0; clr_stat = 0;
        exp_live = '{pre: 6'd8, en: 1'b1, typ: 1'b0};
        step(); step();
        check_reset();
        rst = 1'b1;
        step();

        // Config write while idle: pending one cycle, applied two cycles after cfg_wr.
        cfg_q.push_back('{pre: 6'd16, en: 1'b0, typ: 1'b1});
        cfg_write(6'd16, 1'b0, 1'b1);
        check("c1_pending", cfg_pending, 1);
        check("c1_live_unchanged", Prescale, 8);
        step();
        check("c1_ack", cfg_ack, 1);
        check("c1_pending_clear", cfg_pending, 0);
        check("c1_prescale", Prescale, 16);
        check("c1_par", {PAR_EN, PAR_TYP}, 2'b01);
        step();
        check("c1_ack_pulse", cfg_ack, 0);

        // Config write blocked by a busy receiver; a second write in the wait is ignored.
        rx_busy = 1'b1;
        cfg_q.push_back('{pre: 6'd32, en: 1'b1, typ: 1'b1});
        cfg_write(6'd32, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                cfg_prescale = 6'd16; cfg_wr = 1'b1;
            end else begin
                cfg_wr = 1'b0;
            end
            check("c2_pending_hold", cfg_pending, 1);
            check("c2_live_hold", Prescale, 16);
            step();
        end
        cfg_wr = 1'b0;
        rx_busy = 1'b0;
        step();
        n = 1;
        while (!cfg_ack && n < 4) begin
            step();
            n++;
        end
        check("c2_ack_seen", cfg_ack, 1);
        check("c2_ack_latency_ok", n <= 2, 1);
        check("c2_prescale", Prescale, 32);
        step();

        // Illegal prescale rejected.
        err_q.push_back(6'd12);
        cfg_write(6'd12, 1'b0, 1'b0);
        check("c3_err", cfg_err, 1);
        step();
        check("c3_err_pulse", cfg_err, 0);
        check("c3_no_pending", cfg_pending, 0);
        check("c3_no_ack", cfg_ack, 0);
        check("c3_prescale", Prescale, 32);

        // Overfill with consumer stalled: fifth byte dropped.
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4); push(8'hE5);
        data_q.push_back(8'hA1); data_q.push_back(8'hB2);
        data_q.push_back(8'hC3); data_q.push_back(8'hD4);
        check("f1_count_full", fifo_count, 4);
        check("f1_overflow", overflow, 1);
        check("f1_head", out_data, 8'hA1);
        drain("f1");

        // Fill/drain rounds of three bytes so both pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                logic [DW-1:0] d;
                d = DW'(8'h30 + r * 16 + k);
                data_q.push_back(d);
                push(d);
            end
            check("f2_count", fifo_count, 3);
            drain("f2");
        end

        // Full FIFO with simultaneous push and pop.
        clr_stat = 1'b1; step(); clr_stat = 1'b0;
        check("f3_ovf_cleared", overflow, 0);
        foreach (data_q[i]) data_q.delete(i);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        data_q.push_back(8'h11); data_q.push_back(8'h22); data_q.push_back(8'h33);
        data_q.push_back(8'h44); data_q.push_back(8'h55);
        rx_data = 8'h55; rx_data_valid = 1'b1; out_ready = 1'b1;
        step();
        rx_data_valid = 1'b0; out_ready = 1'b0;
        check("f3_count", fifo_count, 4);
        check("f3_no_overflow", overflow, 0);
        check("f3_head", out_data, 8'h22);
        drain("f3");

        // Saturating counters and clear-with-event.
        rx_par_err = 1'b1;
        repeat (300) step();
        rx_par_err = 1'b0;
        check("s1_par_sat", par_err_cnt, 255);
        rx_stop_err = 1'b1;
        repeat (3) step();
        rx_stop_err = 1'b0;
        check("s1_stop3", stop_err_cnt, 3);
        clr_stat = 1'b1; rx_stop_err = 1'b1;
        step();
        clr_stat = 1'b0; rx_stop_err = 1'b0;
        check("s2_par_cleared", par_err_cnt, 0);
        check("s2_stop_clr_evt", stop_err_cnt, 1);
        rx_par_err = 1'b1; rx_stop_err = 1'b1;
        step();
        rx_par_err = 1'b0; rx_stop_err = 1'b0;
        check("s3_par_both", par_err_cnt, 1);
        check("s3_stop_both", stop_err_cnt, 2);

        // Reset mid-frame with config pending and FIFO half full.
        rx_busy = 1'b1;
        cfg_write(6'd16, 1'b0, 1'b0);
        push(8'h77); push(8'h88);
        check("r1_pre_count", fifo_count, 2);
        check("r1_pre_pending", cfg_pending, 1);
        rst = 1'b0;
        step();
        check_reset();
        rst = 1'b1; rx_busy = 1'b0;
        exp_live = '{pre: 6'd8, en: 1'b1, typ: 1'b0};
        repeat (4) step();
        check("r1_no_late_ack", cfg_ack, 0);
        check("r1_still_8", Prescale, 8);

        check("end_cfg_q_empty", cfg_q.size(), 0);
        check("end_err_q_empty", err_q.size(), 0);
        check("end_data_q_empty", data_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
